clickreg_fifo: RTL and testbench

Parametrised multichannel pulse registration and time-stamping block, the successor to the fixed 4+4-channel click register. It timestamps strobe events (level or rising-edge mode) and delta-channel state changes against a free-running timer, and emits wrap-around markers. Records are buffered in an internal FIFO behind a valid/ready handshake, so downstream back-pressure never corrupts data. Records lost to contention or overflow are flagged and counted. Sits between the input synchronisers and the USB/readout record path.

---
 rtl/clickreg_pkg.sv | 39 +++
 rtl/record_fifo.sv | 76 +++++++
 rtl/clickreg_fifo.sv | 144 ++++++++++++++
 tb/tb_clickreg_fifo.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/clickreg_pkg.sv
// Shared definitions for the click register record path.
// Provides the record type codes, a ceil-log2 helper and the functions that
// derive the channel field width, the record width and the bit offsets of the
// flag fields from the block parameters.
package clickreg_pkg;

  localparam logic REC_TYPE_STROBE = 1'b0;  // strobe events and wrap markers
  localparam logic REC_TYPE_DELTA  = 1'b1;  // delta-channel state changes

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Channel field is wide enough for either channel group.
  function automatic int ch_width(input int n_strobe, input int n_delta);
    return (n_strobe > n_delta) ? n_strobe : n_delta;
  endfunction

  // Layout, LSB first: timestamp, channels, lost, type, wrap.
  function automatic int rec_width(input int timer_w, input int ch_w);
    return timer_w + ch_w + 3;
  endfunction

  function automatic int lost_offset(input int timer_w, input int ch_w);
    return timer_w + ch_w;
  endfunction

  function automatic int type_offset(input int timer_w, input int ch_w);
    return timer_w + ch_w + 1;
  endfunction

  function automatic int wrap_offset(input int timer_w, input int ch_w);
    return timer_w + ch_w + 2;
  endfunction

endpackage

// File: rtl/record_fifo.sv
// First-word-fall-through record FIFO.
// Ports:
//   clk        system clock
//   clear      synchronous active-high flush
//   push       write push_data (accepted when not full, or full with a pop)
//   push_data  record to write
//   pop        remove the head record (ignored when empty)
//   pop_data   head record, 0 when empty
//   full       DEPTH records stored
//   empty      no record stored
module record_fifo
  import clickreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // A pop frees the head slot in the same edge, so a push while full is
  // still accepted when it coincides with a pop.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Head is read straight from the array so it is visible one edge after
  // the push that filled an empty FIFO.
  assign pop_data = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/clickreg_fifo.sv
// Multichannel pulse registration and time-stamping block.
// Timestamps strobe events and delta-channel changes against a free-running
// timer, emits wrap markers, and buffers records in a FWFT FIFO.
// Ports:
//   clk              system clock
//   clear            synchronous active-high reset
//   operate          enables record generation (timer always runs)
//   strobe_channels  synchronised strobe inputs
//   delta_channels   synchronised state inputs
//   strobe_enable    per-channel strobe mask, 1 = enabled
//   data_ready       consumer accepts the head record
//   data             head record {wrap, type, lost, channels, timestamp}
//   data_valid       head record valid
//   lost_count       saturating count of dropped records
//   overflow         sticky, at least one record dropped
module clickreg_fifo
  import clickreg_pkg::*;
#(
  parameter int N_STROBE   = 4,
  parameter int N_DELTA    = 4,
  parameter int TIMER_W    = 36,
  parameter int FIFO_DEPTH = 16,
  parameter int LOST_W     = 16,
  parameter int EDGE_MODE  = 1,
  localparam int CH_W      = ch_width(N_STROBE, N_DELTA),
  localparam int REC_W     = rec_width(TIMER_W, CH_W)
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                operate,
  input  logic [N_STROBE-1:0] strobe_channels,
  input  logic [N_DELTA-1:0]  delta_channels,
  input  logic [N_STROBE-1:0] strobe_enable,
  input  logic                data_ready,
  output logic [REC_W-1:0]    data,
  output logic                data_valid,
  output logic [LOST_W-1:0]   lost_count,
  output logic                overflow
);

  logic [TIMER_W-1:0]  timer_q;
  logic [N_STROBE-1:0] prev_strobe_q;
  logic [N_DELTA-1:0]  old_delta_q;
  logic                pending_lost_q, pending_lost_d;
  logic [LOST_W-1:0]   lost_count_q, lost_count_d;
  logic                overflow_q, overflow_d;

  logic [N_STROBE-1:0] strobe_ev;
  logic                cand_valid, cand_type, contention;
  logic [CH_W-1:0]     cand_ch;
  logic [REC_W-1:0]    cand_rec;
  logic                pop, write_ok, drop;
  logic                fifo_full, fifo_empty;
  logic [LOST_W:0]     lost_sum;

  generate
    if (EDGE_MODE != 0) begin : g_edge
      assign strobe_ev = strobe_channels & ~prev_strobe_q & strobe_enable;
    end else begin : g_level
      assign strobe_ev = strobe_channels & strobe_enable;
    end
  endgenerate

  // Candidate selection: delta change beats strobe beats wrap marker.
  always_comb begin
    cand_valid = 1'b0;
    cand_type  = REC_TYPE_STROBE;
    cand_ch    = '0;
    contention = 1'b0;
    if (operate) begin
      if (delta_channels != old_delta_q) begin
        cand_valid             = 1'b1;
        cand_type              = REC_TYPE_DELTA;
        cand_ch[N_DELTA-1:0]   = delta_channels;
        contention             = |strobe_ev;
      end else if (|strobe_ev) begin
        cand_valid             = 1'b1;
        cand_ch[N_STROBE-1:0]  = strobe_ev;
      end else if (timer_q == '0) begin
        cand_valid             = 1'b1;
      end
    end
  end

  assign cand_rec = {(timer_q == '0), cand_type, pending_lost_q, cand_ch, timer_q};

  assign pop      = data_valid & data_ready;
  assign write_ok = cand_valid & (~fifo_full | pop);
  assign drop     = cand_valid & ~write_ok;

  // Up to two records can be lost in one cycle (contended strobe plus a
  // delta record that found the FIFO full).
  assign lost_sum = {1'b0, lost_count_q}
                  + (LOST_W+1)'({1'b0, contention} + {1'b0, drop});

  always_comb begin
    pending_lost_d = pending_lost_q;
    overflow_d     = overflow_q | drop;
    lost_count_d   = lost_sum[LOST_W] ? '1 : lost_sum[LOST_W-1:0];
    if (operate) begin
      // The written record reports the old flag; a loss in this cycle
      // re-arms it for the next record.
      if (write_ok)          pending_lost_d = 1'b0;
      if (drop | contention) pending_lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      timer_q        <= '0;
      prev_strobe_q  <= '0;
      old_delta_q    <= '0;
      pending_lost_q <= 1'b0;
      lost_count_q   <= '0;
      overflow_q     <= 1'b0;
    end else begin
      timer_q        <= timer_q + 1'b1;
      prev_strobe_q  <= strobe_channels;
      old_delta_q    <= delta_channels;
      pending_lost_q <= pending_lost_d;
      lost_count_q   <= lost_count_d;
      overflow_q     <= overflow_d;
    end
  end

  record_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clear     (clear),
    .push      (write_ok),
    .push_data (cand_rec),
    .pop       (pop),
    .pop_data  (data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign data_valid = ~fifo_empty;
  assign lost_count = lost_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_clickreg_fifo.sv
module tb_clickreg_fifo;

  localparam int NS    = 4;
  localparam int ND    = 4;
  localparam int TW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = 16;
  localparam int RW    = TW + 4 + 3;

  logic          clk = 1'b0;
  logic          clear = 1'b1;
  logic          operate = 1'b0;
  logic [NS-1:0] strobe_channels = '0;
  logic [ND-1:0] delta_channels = '0;
  logic [NS-1:0] strobe_enable = '1;
  logic          data_ready = 1'b0;
  logic [RW-1:0] data;
  logic          data_valid;
  logic [LW-1:0] lost_count;
  logic          overflow;

  always #5 clk = ~clk;

  clickreg_fifo #(
    .N_STROBE   (NS),
    .N_DELTA    (ND),
    .TIMER_W    (TW),
    .FIFO_DEPTH (DEPTH),
    .LOST_W     (LW),
    .EDGE_MODE  (1)
  ) dut (
    .clk             (clk),
    .clear           (clear),
    .operate         (operate),
    .strobe_channels (strobe_channels),
    .delta_channels  (delta_channels),
    .strobe_enable   (strobe_enable),
    .data_ready      (data_ready),
    .data            (data),
    .data_valid      (data_valid),
    .lost_count      (lost_count),
    .overflow        (overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: elapsed cycles since clear, last-seen inputs, and a
  // queue of records that should be sitting in the FIFO.
  int            m_cycles;
  logic [NS-1:0] m_prev;
  logic [ND-1:0] m_old;
  bit            m_pend;
  bit            m_ovf;
  int            m_lost;
  logic [RW-1:0] m_q[$];

  function automatic logic [RW-1:0] make_rec(input int ts, input logic [3:0] ch,
                                             input bit lost, input bit typ);
    logic [TW-1:0] t;
    t = TW'(ts % 256);
    return {(t == 0), typ, lost, ch, t};
  endfunction

  task automatic model_step(input bit clr, input bit op, input bit rdy,
                            input logic [3:0] stb, input logic [3:0] en,
                            input logic [3:0] dl);
    logic [3:0]    ev;
    bit            have, contended, popped;
    logic [RW-1:0] rec;
    int            ts, inc;
    if (clr) begin
      m_cycles = 0; m_prev = '0; m_old = '0;
      m_pend = 0; m_ovf = 0; m_lost = 0;
      m_q.delete();
      return;
    end
    ts = m_cycles % 256;
    ev = stb & ~m_prev & en;
    have = 0; contended = 0; inc = 0; rec = '0;
    if (op) begin
      if (dl != m_old) begin
        have = 1; rec = make_rec(ts, dl, m_pend, 1'b1); contended = (ev != 0);
      end else if (ev != 0) begin
        have = 1; rec = make_rec(ts, ev, m_pend, 1'b0);
      end else if (ts == 0) begin
        have = 1; rec = make_rec(ts, 4'b0, m_pend, 1'b0);
      end
    end
    popped = (m_q.size() > 0) && rdy;
    if (popped) begin
      $display("pop rec=%h ts=%0d ch=%b lost=%0d type=%0d wrap=%0d",
               m_q[0], m_q[0][TW-1:0], m_q[0][TW+3:TW], m_q[0][TW+4],
               m_q[0][TW+5], m_q[0][TW+6]);
      void'(m_q.pop_front());
    end
    if (contended) inc++;
    if (have) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back(rec);
        m_pend = 0;
      end else begin
        inc++; m_ovf = 1; m_pend = 1;
      end
    end
    if (contended) m_pend = 1;
    m_lost = (m_lost + inc > 65535) ? 65535 : m_lost + inc;
    m_prev = stb; m_old = dl;
    m_cycles++;
  endtask

  task automatic cyc(input bit clr, input bit op, input bit rdy,
                     input logic [3:0] stb, input logic [3:0] en, input logic [3:0] dl);
    logic [RW-1:0] exp_data;
    @(negedge clk);
    clear = clr; operate = op; data_ready = rdy;
    strobe_channels = stb; strobe_enable = en; delta_channels = dl;
    model_step(clr, op, rdy, stb, en, dl);
    @(posedge clk);
    #1;
    exp_data = (m_q.size() > 0) ? m_q[0] : '0;
    check_val("data_valid", 32'(data_valid), 32'(m_q.size() > 0));
    check_val("data", 32'(data), 32'(exp_data));
    check_val("lost_count", 32'(lost_count), 32'(m_lost));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  initial begin
    // Reset, then a three-cycle strobe on channels 0 and 2.
    cyc(1, 0, 1, 4'h0, 4'hf, 4'h0);
    cyc(1, 0, 1, 4'h0, 4'hf, 4'h0);
    check_val("reset_valid", 32'(data_valid), 32'd0);
    check_val("reset_lost", 32'(lost_count), 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 4'b0101, 4'hf, 4'h0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 4'b0000, 4'hf, 4'h0);

    // Delta change colliding with a strobe rise, then two more strobes.
    cyc(0, 1, 1, 4'b0001, 4'hf, 4'b0011);
    cyc(0, 1, 1, 4'b0000, 4'hf, 4'b0011);
    check_val("contention_lost", 32'(lost_count), 32'd1);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 1, 4'b0010, 4'hf, 4'b0011);
      cyc(0, 1, 1, 4'b0000, 4'hf, 4'b0011);
    end

    // Stalled consumer with 20 strobes, then drain.
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0, 4'b1000, 4'hf, 4'b0011);
      cyc(0, 1, 0, 4'b0000, 4'hf, 4'b0011);
    end
    check_val("burst_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 24; i++) cyc(0, 1, 1, 4'b0000, 4'hf, 4'b0011);

    // Idle with operate low (no wrap markers), then high (markers).
    for (int i = 0; i < 300; i++) cyc(0, 0, 1, 4'b0000, 4'hf, 4'b0011);
    for (int i = 0; i < 600; i++) cyc(0, 1, 1, 4'b0000, 4'hf, 4'b0011);

    // Fill the FIFO, then push and pop in the same cycle.
    for (int i = 0; i < 18; i++) begin
      cyc(0, 1, 0, 4'b0100, 4'hf, 4'b0011);
      cyc(0, 1, 0, 4'b0000, 4'hf, 4'b0011);
    end
    cyc(0, 1, 1, 4'b0100, 4'hf, 4'b0011);
    cyc(0, 1, 0, 4'b0000, 4'hf, 4'b0011);

    // Queue a few records and clear mid-stream.
    cyc(0, 1, 1, 4'b0000, 4'hf, 4'b0011);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 4'b0001, 4'hf, 4'b0011);
      cyc(0, 1, 0, 4'b0000, 4'hf, 4'b0011);
    end
    cyc(1, 1, 0, 4'b1111, 4'hf, 4'b1111);
    check_val("clear_valid", 32'(data_valid), 32'd0);
    check_val("clear_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 4'b0000, 4'hf, 4'b0000);

    // Randomised traffic.
    for (int i = 0; i < 2500; i++) begin
      logic [3:0] dl;
      dl = ($urandom_range(0, 7) == 0) ? 4'($urandom) : delta_channels;
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 9) < 6), 4'($urandom), 4'($urandom), dl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
